ex_div: RTL and testbench
=========================

EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have start_i  input  1  request a divide; operands and op valid in the same cycle.
REQ-005 SHALL have op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (low bits of RV32M funct3).
REQ-006 SHALL have dividend_i  input  WIDTH  op1 from the ID/EX register.
REQ-007 SHALL have divisor_i  input  WIDTH  op2 from the ID/EX register.
REQ-008 SHALL have rd_addr_i  input  5  destination register of the divide instruction.
REQ-009 SHALL have flush_i  input  1  pipeline flush from ctrl; aborts an in-flight divide.
REQ-010 SHALL have result_o  output  WIDTH  quotient or remainder.
REQ-011 SHALL have ready_o  output  1  one-cycle pulse: result_o/rd_addr_o valid.
REQ-012 SHALL have reg_wen_o  output  1  register-file write enable, equal to ready_o.
REQ-013 SHALL have rd_addr_o  output  5  captured destination register.
REQ-014 SHALL have busy_o  output  1  high in CALC and END.
REQ-015 SHALL have hold_req_o  output  1  stall request to ctrl, freezing IF/ID and ID/EX.

Function
REQ-016 SHALL implement states IDLE, CALC, END; transitions only on rising clk.
REQ-017 IDLE: start_i=1 and flush_i=0 SHALL capture op_i, rd_addr_i and operands at edge N.
REQ-018 On capture, divisor=0 or (op DIV/REM, dividend=0x80000000, divisor=0xFFFFFFFF) SHALL go to END; otherwise to CALC with counter=0.
REQ-019 Signed ops SHALL divide absolute values and record quotient sign (dividend sign XOR divisor sign) and remainder sign (dividend sign).
REQ-020 CALC SHALL run one restoring radix-2 step per cycle for exactly WIDTH cycles (edges N+1..N+WIDTH), then go to END.
REQ-021 END SHALL last one cycle, assert ready_o=reg_wen_o=1 with registered result_o and rd_addr_o, then return to IDLE.
REQ-022 Normal-case latency: ready_o high in the cycle after edge N+WIDTH; special-case latency: ready_o high in the cycle after edge N.
REQ-023 Divide by zero SHALL give DIV/DIVU 0xFFFFFFFF, REM/REMU dividend_i unchanged.
REQ-024 Signed overflow SHALL give DIV 0x80000000, REM 0.
REQ-025 Signed results SHALL be two's-complement negated when the recorded sign is 1; unsigned results used as computed.
REQ-026 hold_req_o SHALL be combinational: (IDLE and start_i and !flush_i) or CALC; low in END so the pipeline advances with the result.
REQ-027 start_i in CALC or END SHALL be ignored; operands captured at edge N SHALL not change.
REQ-028 flush_i=1 in any state SHALL force IDLE at the next edge with no ready_o pulse; flush_i takes priority over simultaneous start_i.
REQ-029 Outside END, ready_o, reg_wen_o SHALL be 0; result_o and rd_addr_o SHALL hold their last values.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, counter 0, result_o 0, rd_addr_o 0, ready_o 0, reg_wen_o 0, busy_o 0, hold_req_o 0.
REQ-031 Reset asserted mid-CALC SHALL discard the operation; no ready_o after reset release until a new start_i.

Verification
REQ-032 DIVU 100/7 -> hold_req_o high from start through CALC; ready_o one cycle after edge N+32; result_o=14, reg_wen_o=1, rd_addr_o as given.
REQ-033 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REMU 0xFFFFFFF9/2 -> 1.
REQ-034 DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, ready_o in cycle after edge N; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-035 flush_i at CALC cycle 10 -> IDLE next edge, no ready_o, hold_req_o low; new start_i next cycle completes normally.
REQ-036 rst_n low at CALC cycle 20 -> all outputs 0 immediately; no ready_o pulse after release.
REQ-037 start_i held high during CALC with changed operands -> result matches the first captured operands; second request ignored.

Source files
------------

// File: rtl/ex_div.sv
// Multi-cycle RV32M divider for the EX stage: restoring radix-2, one bit
// per cycle, with divide-by-zero and signed-overflow results in one cycle.
module ex_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic [4:0]       rd_addr_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] result_o,
    output logic             ready_o,
    output logic             reg_wen_o,
    output logic [4:0]       rd_addr_o,
    output logic             busy_o,
    output logic             hold_req_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_END
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_rem_op;
    logic             r_qsign;
    logic             r_rsign;
    logic [4:0]       r_rd;
    logic [4:0]       r_rd_o;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_result;

    logic             w_capture;
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic             w_div0;
    logic             w_ovf;
    logic             w_special;
    logic [WIDTH-1:0] w_special_res;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_r_next;
    logic [WIDTH-1:0] w_final;

    assign w_capture = (r_state == S_IDLE) && start_i && !flush_i;
    assign w_signed  = ~op_i[0];
    assign w_a_neg   = w_signed & dividend_i[WIDTH-1];
    assign w_b_neg   = w_signed & divisor_i[WIDTH-1];
    assign w_a_abs   = w_a_neg ? -dividend_i : dividend_i;
    assign w_b_abs   = w_b_neg ? -divisor_i : divisor_i;
    assign w_div0    = (divisor_i == '0);
    assign w_ovf     = w_signed
                     && (dividend_i == {1'b1, {(WIDTH-1){1'b0}}})
                     && (&divisor_i);
    assign w_special = w_div0 | w_ovf;

    // Overflow DIV returns the most-negative value, i.e. the dividend itself
    assign w_special_res = op_i[1]
                         ? (w_div0 ? dividend_i : '0)
                         : (w_div0 ? '1 : dividend_i);

    assign w_shift  = {r_rem, r_quo[WIDTH-1]};
    assign w_diff   = w_shift - {1'b0, r_dvs};
    assign w_ge     = ~w_diff[WIDTH];
    assign w_q_next = {r_quo[WIDTH-2:0], w_ge};
    assign w_r_next = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_final  = r_rem_op
                    ? (r_rsign ? -w_r_next : w_r_next)
                    : (r_qsign ? -w_q_next : w_q_next);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flush_i) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:  if (start_i) w_next = w_special ? S_END : S_CALC;
                S_CALC:  if (r_cnt == LAST) w_next = S_END;
                S_END:   w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o    = (r_state == S_END);
        reg_wen_o  = (r_state == S_END);
        busy_o     = (r_state == S_CALC) || (r_state == S_END);
        hold_req_o = rst_n && (w_capture || (r_state == S_CALC));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_rem_op <= 1'b0;
            r_qsign  <= 1'b0;
            r_rsign  <= 1'b0;
            r_rd     <= '0;
            r_rd_o   <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_result <= '0;
        end else if (w_capture) begin
            r_cnt    <= '0;
            r_rem_op <= op_i[1];
            r_qsign  <= w_a_neg ^ w_b_neg;
            r_rsign  <= w_a_neg;
            r_rd     <= rd_addr_i;
            r_quo    <= w_a_abs;
            r_rem    <= '0;
            r_dvs    <= w_b_abs;
            if (w_special) begin
                r_result <= w_special_res;
                r_rd_o   <= rd_addr_i;
            end
        end else if (r_state == S_CALC && !flush_i) begin
            r_quo <= w_q_next;
            r_rem <= w_r_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
                r_result <= w_final;
                r_rd_o   <= r_rd;
            end
        end
    end

    assign result_o  = r_result;
    assign rd_addr_o = r_rd_o;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed vector table, corner-case
// sequences (flush, reset, held start) and randomized ops vs. a model.
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        reg_wen_o;
    logic [4:0]  rd_addr_o;
    logic        busy_o;
    logic        hold_req_o;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ex_div #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .rd_addr_i  (rd_addr_i),
        .flush_i    (flush_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .reg_wen_o  (reg_wen_o),
        .rd_addr_o  (rd_addr_o),
        .busy_o     (busy_o),
        .hold_req_o (hold_req_o)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return op[1] ? 32'h0 : 32'h8000_0000;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return op[1] ? r[31:0] : q[31:0];
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic bit is_special(input logic [1:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 0) ||
               (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Issues one divide and checks latency, hold, result and writeback
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input string nm);
        int lat;
        bit hold_bad;
        int want_lat;
        want_lat = is_special(op, a, b) ? 1 : 33;
        hold_bad = 0;
        @(negedge clk);
        start_i = 1'b1;
        op_i = op;
        dividend_i = a;
        divisor_i = b;
        rd_addr_i = rd;
        #1;
        chk({nm, "_hold0"}, {31'b0, hold_req_o}, 32'd1);
        @(negedge clk);
        start_i = 1'b0;
        dividend_i = ~a;
        divisor_i = ~b;
        rd_addr_i = ~rd;
        lat = 1;
        while (!ready_o && lat < 60) begin
            if (!hold_req_o) hold_bad = 1;
            @(negedge clk);
            lat++;
        end
        chk({nm, "_lat"}, lat, want_lat);
        chk({nm, "_hold"}, {31'b0, hold_bad | hold_req_o}, 32'd0);
        chk({nm, "_res"}, result_o, exp);
        chk({nm, "_rd"}, {27'b0, rd_addr_o}, {27'b0, rd});
        chk({nm, "_wen"}, {31'b0, reg_wen_o}, 32'd1);
        @(negedge clk);
        chk({nm, "_rdy0"}, {30'b0, ready_o, reg_wen_o}, 32'd0);
        chk({nm, "_held"}, result_o, exp);
    endtask

    vec_t tbl[10];
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0]  rrd;
    bit          seen;

    initial begin
        tbl[0] = '{2'b01, 32'd100,        32'd7,         32'd14};
        tbl[1] = '{2'b00, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        tbl[2] = '{2'b10, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        tbl[3] = '{2'b11, 32'hFFFF_FFF9,  32'd2,         32'd1};
        tbl[4] = '{2'b00, 32'd5,          32'd0,         32'hFFFF_FFFF};
        tbl[5] = '{2'b11, 32'd5,          32'd0,         32'd5};
        tbl[6] = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        tbl[7] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        tbl[8] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        tbl[9] = '{2'b00, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD};

        rst_n = 1'b0;
        start_i = 1'b0;
        flush_i = 1'b0;
        op_i = '0;
        dividend_i = '0;
        divisor_i = '0;
        rd_addr_i = '0;
        #12;
        chk("rst_res", result_o, 32'd0);
        chk("rst_flags", {22'b0, rd_addr_o, ready_o, reg_wen_o,
                          busy_o, hold_req_o, 1'b0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 5'(i + 3), tbl[i].exp,
                   $sformatf("vec%0d", i));

        // Flush at CALC cycle 10, then a fresh request completes
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd100;
        divisor_i = 32'd7; rd_addr_i = 5'd9;
        @(negedge clk);
        start_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (ready_o) seen = 1;
            @(negedge clk);
        end
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush_idle", {29'b0, busy_o, hold_req_o, ready_o | seen}, 32'd0);
        run_op(2'b00, 32'hFFFF_FF9C, 32'd7, 5'd10, 32'hFFFF_FFF2, "postflush");

        // Simultaneous start and flush in IDLE is dropped
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b1;
        #1;
        chk("sf_hold", {31'b0, hold_req_o}, 32'd0);
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        chk("sf_idle", {30'b0, busy_o, ready_o}, 32'd0);

        // Reset mid-CALC discards the divide
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd1000;
        divisor_i = 32'd3; rd_addr_i = 5'd17;
        @(negedge clk);
        start_i = 1'b0;
        for (int c = 0; c < 19; c++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstc_res", result_o, 32'd0);
        chk("rstc_flags", {27'b0, ready_o, reg_wen_o, busy_o,
                           hold_req_o, |rd_addr_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready_o || busy_o) seen = 1;
        end
        chk("rstc_noready", {31'b0, seen}, 32'd0);

        // start_i held through CALC with changed operands
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd100;
        divisor_i = 32'd7; rd_addr_i = 5'd21;
        @(negedge clk);
        dividend_i = 32'd1000; divisor_i = 32'd3; rd_addr_i = 5'd4;
        begin
            int lat;
            lat = 1;
            while (!ready_o && lat < 60) begin
                @(negedge clk);
                lat++;
            end
            start_i = 1'b0;
            chk("held_lat", lat, 32'd33);
            chk("held_res", result_o, 32'd14);
            chk("held_rd", {27'b0, rd_addr_o}, 32'd21);
        end
        @(negedge clk);
        chk("held_idle", {30'b0, busy_o, ready_o}, 32'd0);

        // Randomized ops vs. arithmetic model
        for (int i = 0; i < 150; i++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0: begin ra = $urandom; rb = 32'd0; end
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom; rb = 32'($urandom_range(1, 20)); end
                3: begin
                    ra = $urandom;
                    rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
                end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            rrd = 5'($urandom);
            run_op(rop, ra, rb, rrd, ref_div(rop, ra, rb),
                   $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
